// File: rtl/cga_pkg.sv
// Shared definitions for the CGA attribute encoder and the palette tools:
// channel widths, the brown palette exception, FSM encoding and a
// majority helper. CGA_ATTR_BLINK_EN (see cga_attr_encoder) does not
// change anything in this package.
package cga_pkg;

  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int IRGB_W = 4;
  localparam int ATTR_W = 2 * IRGB_W;

  // Brown is the one CGA entry whose green is not a plain level expansion.
  localparam logic [R_W-1:0]    BROWN_R    = 5'b10101;
  localparam logic [G_W-1:0]    BROWN_G    = 6'b010101;
  localparam logic [B_W-1:0]    BROWN_B    = 5'b00000;
  localparam logic [IRGB_W-1:0] IRGB_BROWN = 4'b0110;

  // S_BG: waiting for the background pixel of a pair.
  // S_FG: background captured, waiting for the foreground pixel.
  typedef enum logic {
    S_BG = 1'b0,
    S_FG = 1'b1
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rgb565_to_irgb.sv
// Combinational RGB565 -> 4-bit CGA irgb quantizer. Every one of the 16
// palette colours maps back to its own code; anything else takes the top
// bit of each channel as r/g/b and a majority vote of the next bits as i.
module rgb565_to_irgb
  import cga_pkg::*;
(
  input  logic [R_W-1:0]    i_red,
  input  logic [G_W-1:0]    i_green,
  input  logic [B_W-1:0]    i_blue,
  output logic [IRGB_W-1:0] o_irgb
);

  // Brown is checked first because its green would otherwise decode as 0.
  always_comb begin
    if ((i_red == BROWN_R) && (i_green == BROWN_G) && (i_blue == BROWN_B)) begin
      o_irgb = IRGB_BROWN;
    end else begin
      o_irgb = {maj3(i_red[3], i_green[4], i_blue[3]), i_red[4], i_green[5], i_blue[4]};
    end
  end

endmodule

// File: rtl/cga_attr_encoder.sv
// Packs background/foreground RGB565 pixel pairs into CGA text attribute
// bytes {bg, fg}. Pixel input and attribute output are valid/ready
// streams: a beat transfers on a clock edge where valid and ready are both
// high; a producer holds valid and data stable until that edge, and ready
// may depend on the consumer's ready but never on this side's valid.
// Build option CGA_ATTR_BLINK_EN adds i_blink, captured with the
// background pixel and placed in o_attr[7] instead of bg intensity.
module cga_attr_encoder
  import cga_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [R_W-1:0]    i_red,
  input  logic [G_W-1:0]    i_green,
  input  logic [B_W-1:0]    i_blue,
  input  logic              i_first,
  input  logic              i_valid,
`ifdef CGA_ATTR_BLINK_EN
  input  logic              i_blink,
`endif
  output logic              o_ready,
  output logic [ATTR_W-1:0] o_attr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_desync,
  output logic [CNT_W-1:0]  o_count
);

  state_e              state_q, state_d;
  logic [IRGB_W-1:0]   bg_q, bg_d;
  logic [ATTR_W-1:0]   attr_q, attr_d;
  logic                valid_q, valid_d;
  logic                desync_q, desync_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IRGB_W-1:0]   pix_irgb;
  logic [IRGB_W-1:0]   bg_nibble;
  logic                pix_xfer;

  // One quantizer is enough: at most one pixel arrives per cycle.
  rgb565_to_irgb u_quant (
    .i_red   (i_red),
    .i_green (i_green),
    .i_blue  (i_blue),
    .o_irgb  (pix_irgb)
  );

  // The stored background already holds the exact upper nibble of the
  // attribute, so packing is the same concatenation in both builds.
`ifdef CGA_ATTR_BLINK_EN
  assign bg_nibble = {i_blink, pix_irgb[2:0]};
`else
  assign bg_nibble = pix_irgb;
`endif

  // Ready is always high while collecting a background; a foreground is
  // only taken when the output register is free or being drained.
  always_comb begin
    o_ready = 1'b1;
    if (state_q == S_FG) begin
      o_ready = ~valid_q | i_ready;
    end
  end

  assign pix_xfer = i_valid & o_ready;

  // Next-state logic: pair sequencing, attribute load, desync and count.
  always_comb begin
    state_d  = state_q;
    bg_d     = bg_q;
    attr_d   = attr_q;
    valid_d  = valid_q & ~i_ready;
    desync_d = 1'b0;
    count_d  = count_q;
    case (state_q)
      S_BG: begin
        if (pix_xfer) begin
          if (i_first) begin
            bg_d    = bg_nibble;
            state_d = S_FG;
          end else begin
            desync_d = 1'b1;
          end
        end
      end
      S_FG: begin
        if (pix_xfer) begin
          if (i_first) begin
            bg_d     = bg_nibble;
            desync_d = 1'b1;
          end else begin
            attr_d  = {bg_q, pix_irgb};
            valid_d = 1'b1;
            count_d = count_q + CNT_W'(1);
            state_d = S_BG;
          end
        end
      end
      default: state_d = S_BG;
    endcase
  end

  // State and output registers; reset drops any half-collected pair.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_BG;
      bg_q     <= '0;
      attr_q   <= '0;
      valid_q  <= 1'b0;
      desync_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      bg_q     <= bg_d;
      attr_q   <= attr_d;
      valid_q  <= valid_d;
      desync_q <= desync_d;
      count_q  <= count_d;
    end
  end

  assign o_attr   = attr_q;
  assign o_valid  = valid_q;
  assign o_desync = desync_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_cga_attr_encoder.sv
// Bench for cga_attr_encoder: table of colour pairs, hand-written
// multi-cycle sequences (wrap, backpressure, desync, async reset, blink)
// and a randomized run against a transaction-level reference model.
module tb_cga_attr_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [4:0]  i_red;
  logic [5:0]  i_green;
  logic [4:0]  i_blue;
  logic        i_first;
  logic        i_valid;
  logic        i_ready;
`ifdef CGA_ATTR_BLINK_EN
  logic        i_blink;
`endif
  logic        o_ready, o_valid, o_desync;
  logic [7:0]  o_attr;
  logic [11:0] o_count;
  logic        o_ready2, o_valid2, o_desync2;
  logic [7:0]  o_attr2;
  logic [1:0]  o_count2;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  cga_attr_encoder #(.CNT_W(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_red(i_red), .i_green(i_green),
    .i_blue(i_blue), .i_first(i_first), .i_valid(i_valid),
`ifdef CGA_ATTR_BLINK_EN
    .i_blink(i_blink),
`endif
    .o_ready(o_ready), .o_attr(o_attr), .o_valid(o_valid), .i_ready(i_ready),
    .o_desync(o_desync), .o_count(o_count)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap case.
  cga_attr_encoder #(.CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_red(i_red), .i_green(i_green),
    .i_blue(i_blue), .i_first(i_first), .i_valid(i_valid),
`ifdef CGA_ATTR_BLINK_EN
    .i_blink(i_blink),
`endif
    .o_ready(o_ready2), .o_attr(o_attr2), .o_valid(o_valid2), .i_ready(i_ready),
    .o_desync(o_desync2), .o_count(o_count2)
  );

`ifdef CGA_ATTR_BLINK_EN
  localparam logic [7:0] ATTR_MASK = 8'h7F;
`else
  localparam logic [7:0] ATTR_MASK = 8'hFF;
`endif

  typedef struct {
    logic [15:0] bg_pix;
    logic [15:0] fg_pix;
    logic [7:0]  exp_attr;
  } vec_t;

  vec_t vecs[18];

  // CGA colour k expanded to 8-bit levels (00/55/AA/FF, brown green 55),
  // then truncated to RGB565.
  function automatic logic [15:0] pal565(input int k);
    logic [3:0] kk;
    logic [7:0] lo, hi, r8, g8, b8;
    kk = 4'(k);
    lo = kk[3] ? 8'h55 : 8'h00;
    hi = kk[3] ? 8'hFF : 8'hAA;
    r8 = kk[2] ? hi : lo;
    g8 = kk[1] ? hi : lo;
    b8 = kk[0] ? hi : lo;
    if (kk == 4'd6) g8 = 8'h55;
    return {r8[7:3], g8[7:2], b8[7:3]};
  endfunction

  // Reference quantizer: exact palette hit wins, else the channel rule.
  function automatic logic [3:0] model_quant(input logic [15:0] pix);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    int ones;
    for (int k = 0; k < 16; k++) begin
      if (pal565(k) == pix) return 4'(k);
    end
    r5 = pix[15:11];
    g6 = pix[10:5];
    b5 = pix[4:0];
    ones = int'(r5[3]) + int'(g6[4]) + int'(b5[3]);
    return {(ones >= 2), r5[4], g6[5], b5[4]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pix, input logic first, input logic valid);
    {i_red, i_green, i_blue} = pix;
    i_first = first;
    i_valid = valid;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) step();
    i_rst_n = 1'b1;
    step();
  endtask

  // Bg then fg with the input held valid; ends with valid dropped.
  task automatic send_pair(input logic [15:0] bg, input logic [15:0] fg);
    drive(bg, 1'b1, 1'b1);
    step();
    drive(fg, 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
  endtask

  logic [3:0] m_bg;
  logic       m_pend, m_valid, m_des, consume, xfer, loaded, exp_ready;
  int         m_count;
  logic [15:0] pix;
  logic [3:0]  nib;
  logic [7:0]  e;
  int          cnt_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(16'h0, 1'b0, 1'b0);
`ifdef CGA_ATTR_BLINK_EN
    i_blink = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin
      vecs[k] = '{pal565(k), pal565(15 - k), 8'(k * 16 + 15 - k)};
    end
    vecs[16] = '{16'b10000_110000_01000, pal565(0), 8'hE0};
    vecs[17] = '{16'b10101_010101_00001, pal565(6), 8'h46};

    // Reset values while reset is held.
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_attr", o_attr, 0);
    check("rst_desync", o_desync, 0);
    check("rst_count", o_count, 0);
    check("rst_ready", o_ready, 1);
    do_reset();

    // Counter wrap on the 2-bit instance.
    for (int n = 0; n < 5; n++) begin
      send_pair(pal565(n), pal565(n + 1));
      check("wrap_count2", o_count2, cnt_seq[n]);
      check("wrap_count12", o_count, n + 1);
    end
    do_reset();

    // Palette round-trip and quantizer table.
    for (int v = 0; v < 18; v++) begin
      send_pair(vecs[v].bg_pix, vecs[v].fg_pix);
      check("tbl_valid", o_valid, 1);
      check("tbl_attr", o_attr, vecs[v].exp_attr & ATTR_MASK);
      if (v == 15) check("tbl_count16", o_count, 16);
    end
    step();
    check("tbl_drain", o_valid, 0);
    check("tbl_count18", o_count, 18);

    // Backpressure: 0x1E held while a new pair waits.
    i_ready = 1'b0;
    send_pair(pal565(1), pal565(14));
    check("bp_attr", o_attr, 8'h1E & ATTR_MASK);
    drive(pal565(2), 1'b1, 1'b1);
    step();
    drive(pal565(5), 1'b0, 1'b1);
    #1;
    check("bp_ready_low", o_ready, 0);
    step();
    check("bp_hold_valid", o_valid, 1);
    check("bp_hold_attr", o_attr, 8'h1E & ATTR_MASK);
    check("bp_hold_count", o_count, 19);
    i_ready = 1'b1;
    #1;
    check("bp_ready_high", o_ready, 1);
    step();
    i_valid = 1'b0;
    check("bp_b2b_valid", o_valid, 1);
    check("bp_new_attr", o_attr, 8'h25 & ATTR_MASK);
    check("bp_count", o_count, 20);
    step();
    check("bp_drain", o_valid, 0);

    // Desync: orphan fg, then a doubled bg.
    drive(pal565(3), 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
    check("ds_orphan_pulse", o_desync, 1);
    check("ds_orphan_novalid", o_valid, 0);
    step();
    check("ds_pulse_end", o_desync, 0);
    drive(pal565(4), 1'b1, 1'b1);
    step();
    check("ds_bg1", o_desync, 0);
    drive(pal565(2), 1'b1, 1'b1);
    step();
    check("ds_bg2_pulse", o_desync, 1);
    drive(pal565(7), 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
    check("ds_fg_nopulse", o_desync, 0);
    check("ds_attr", o_attr, 8'h27);
    check("ds_count", o_count, 21);
    step();

    // Asynchronous reset with an attribute pending and a bg captured.
    i_ready = 1'b0;
    send_pair(pal565(3), pal565(9));
    drive(pal565(5), 1'b1, 1'b1);
    step();
    i_valid = 1'b0;
    check("ar_setup_valid", o_valid, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_valid", o_valid, 0);
    check("ar_attr", o_attr, 0);
    check("ar_count", o_count, 0);
    #2;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    drive(pal565(10), 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
    check("ar_fg_desync", o_desync, 1);
    check("ar_fg_novalid", o_valid, 0);
    step();

`ifdef CGA_ATTR_BLINK_EN
    // Blink bit replaces bg intensity.
    i_blink = 1'b1;
    send_pair(pal565(12), pal565(15));
    i_blink = 1'b0;
    check("blink_on", o_attr, 8'hCF);
    send_pair(pal565(12), pal565(15));
    check("blink_off", o_attr, 8'h4F);
    step();
`endif

    // Randomized run against the transaction model.
    do_reset();
    m_pend = 0; m_valid = 0; m_count = 0; m_bg = '0;
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_first = m_pend ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      pix = $urandom_range(0, 1) ? pal565(int'($urandom_range(0, 15))) : 16'($urandom);
      {i_red, i_green, i_blue} = pix;
`ifdef CGA_ATTR_BLINK_EN
      i_blink = 1'($urandom_range(0, 1));
`endif
      #1;
      exp_ready = !m_pend || !m_valid || i_ready;
      check("rnd_ready", o_ready, exp_ready);
      consume = m_valid && i_ready;
      if (consume) begin
        check("rnd_q_size", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_attr", o_attr, e);
        end
      end
      xfer = i_valid && exp_ready;
      loaded = 0;
      m_des = 0;
      if (xfer) begin
        nib = model_quant(pix);
        if (i_first) begin
          m_des = m_pend;
`ifdef CGA_ATTR_BLINK_EN
          m_bg = {i_blink, nib[2:0]};
`else
          m_bg = nib;
`endif
          m_pend = 1;
        end else if (m_pend) begin
          exp_q.push_back({m_bg, nib});
          loaded = 1;
          m_pend = 0;
          m_count++;
        end else begin
          m_des = 1;
        end
      end
      if (loaded) m_valid = 1;
      else if (consume) m_valid = 0;
      step();
      check("rnd_valid", o_valid, m_valid);
      check("rnd_desync", o_desync, m_des);
      check("rnd_count", o_count, m_count % 4096);
      check("rnd_count2", o_count2, m_count % 4);
      check("rnd_valid2", o_valid2, m_valid);
      check("rnd_desync2", o_desync2, m_des);
      if (m_valid) check("rnd_attr2", o_attr2, o_attr);
      if (o_ready2 !== o_ready) check("rnd_ready2", o_ready2, o_ready);
    end
    check("rnd_q_final", 32'(exp_q.size()), m_valid ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
